uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of flip-flops in the rxd synchronizer (minimum 2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: receive FIFO entries, a power of two; used only when UART_RX_FIFO_EN is defined.
REQ-003 SHALL have port clk  in  1  system clock, rising edge.
REQ-004 SHALL have port rstn  in  1  reset.
REQ-005 SHALL have port period  in  16  clocks per bit; 2604 gives 9600 baud at 25 MHz.
REQ-006 SHALL have port rxd  in  1  asynchronous serial line, idle high.
REQ-007 SHALL have port rx_clear  in  1  pop/acknowledge of the current byte.
REQ-008 SHALL have port rx_data  out  8  oldest unread byte.
REQ-009 SHALL have port rx_ready  out  1  at least one unread byte held.
REQ-010 SHALL have port frame_err  out  1  sticky flag: a stop bit was sampled low.
REQ-011 SHALL have port overrun  out  1  sticky flag: a byte was dropped because storage was full.
REQ-012 SHALL use one clock, clk; reset rstn is asynchronous and active-low.

Function
REQ-013 SHALL sample rxd through SYNC_STAGES flip-flops before any other use; all references to the line below mean the synchronized value.
REQ-014 SHALL implement a four-state FSM: IDLE, START, DATA, STOP.
REQ-015 SHALL latch period into an internal register on leaving IDLE; changes to period mid-frame SHALL have no effect until the next frame.
REQ-016 SHALL treat a latched period below 2 as 2.
REQ-017 IDLE: SHALL go to START on a falling edge of the line, i.e. the previous sample is 1 and the current sample is 0; it clears the bit counter.
REQ-018 START: after period/2 clocks (integer division), if the line is 0 SHALL go to DATA, otherwise SHALL return to IDLE as a glitch, with no flag set.
REQ-019 DATA: SHALL sample one bit every period clocks and shift it in LSB first; after the 8th sample it SHALL go to STOP.
REQ-020 STOP: after period clocks it SHALL sample the line; if the sample is 1 it SHALL commit the byte to storage; if 0 it SHALL set frame_err and discard the byte; in both cases it SHALL go to IDLE.
REQ-021 Commit SHALL happen on the stop-sample clock edge; rx_ready and rx_data SHALL be valid from the following cycle.
REQ-022 rx_clear while rx_ready=1 SHALL remove the head byte at the clock edge; rx_clear while rx_ready=0 SHALL be ignored.
REQ-023 A commit and a clear in the same cycle SHALL both take effect; occupancy is unchanged and the byte is not counted as overrun, even when storage is full.
REQ-024 A commit into full storage with no simultaneous clear SHALL drop the new byte and set overrun; stored bytes are kept.
REQ-025 frame_err and overrun SHALL clear on any accepted rx_clear, unless the same cycle sets them again; setting wins.
REQ-026 The bit-timing counter SHALL be 16 bits and SHALL reset to 0 at every sample point.

Reset
REQ-027 On rstn=0: FSM to IDLE; counters, shift register and storage pointers cleared; synchronizer stages set to 1.
REQ-028 Output reset values SHALL be rx_data=0x00, rx_ready=0, frame_err=0, overrun=0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame; after release no partial byte SHALL appear.

Configuration
REQ-030 Macro UART_RX_FIFO_EN defined: storage SHALL be a FIFO_DEPTH-entry FIFO; rx_data shows the head entry.
REQ-031 Macro UART_RX_FIFO_EN undefined: storage SHALL be a single holding register, equivalent to depth 1; the FIFO logic is absent.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, the default divisor constant 2604, and the data width of 8.
REQ-033 The FIFO SHALL be a sub-module named uart_rx_fifo, instantiated only under UART_RX_FIFO_EN.

Verification
REQ-034 Scenario: period=16, send 0xA5 (8N1) -> rx_ready rises one cycle after the stop sample, rx_data=0xA5, no flags set.
REQ-035 Scenario: period=16, rxd low for 4 cycles then high -> FSM returns to IDLE, rx_ready=0, frame_err=0.
REQ-036 Scenario: send 0x3C with the stop bit driven 0 -> frame_err=1, rx_ready=0; a later rx_clear clears frame_err.
REQ-037 Scenario: without the macro, send 0x11 then 0x22 with no clear -> rx_data=0x11, overrun=1; with the macro, send 5 bytes -> 4 stored, overrun=1, reads return bytes in order.
REQ-038 Scenario: storage full, rx_clear pulsed on the commit cycle -> no overrun; occupancy unchanged; the new byte is at the tail.
REQ-039 Scenario: rstn pulsed during DATA, then 0x5A sent -> only 0x5A received; period changed mid-frame -> the current byte is still correct.

Source files
------------

// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, default
// bit divisor and data width.
package uart_receiver_pkg;

  localparam int          DATA_W         = 8;
  localparam logic [15:0] DEFAULT_PERIOD = 16'd2604;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // A divisor below 2 would make the half-bit wait zero clocks long.
  function automatic logic [15:0] clamp_period(input logic [15:0] p);
    return (p < 16'd2) ? 16'd2 : p;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO for the UART receiver; push and pop in the same cycle are
// both honoured even when full.
module uart_rx_fifo
  import uart_receiver_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with synchronizer, sticky error flags and receive storage.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO instead of one holding register.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [15:0]       period,
  input  logic              rxd,
  input  logic              rx_clear,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_ready,
  output logic              frame_err,
  output logic              overrun
);

  if (SYNC_STAGES < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_receiver: SYNC_STAGES must be >= 2 and FIFO_DEPTH a power of two >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   line;
  logic                   prev_line;

  rx_state_t         state, state_next;
  logic [15:0]       cnt, cnt_next;
  logic [15:0]       per_q, per_next;
  logic [15:0]       half_m1;
  logic [15:0]       per_m1;
  logic [2:0]        bit_cnt, bit_cnt_next;
  logic [DATA_W-1:0] shift_q, shift_next;
  logic              commit;
  logic              frame_set;

  logic              clear_acc;
  logic              full;
  logic              overrun_set;

  assign line = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q    <= '1;
      prev_line <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rxd};
      prev_line <= line;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      per_q   <= DEFAULT_PERIOD;
      bit_cnt <= '0;
      shift_q <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      per_q   <= per_next;
      bit_cnt <= bit_cnt_next;
      shift_q <= shift_next;
    end
  end

  assign half_m1 = {1'b0, per_q[15:1]} - 16'd1;
  assign per_m1  = per_q - 16'd1;

  // The bit timer restarts at every sample point, so each wait is measured
  // from the previous sample rather than from the start edge.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt + 16'd1;
    per_next     = per_q;
    bit_cnt_next = bit_cnt;
    shift_next   = shift_q;
    commit       = 1'b0;
    frame_set    = 1'b0;
    case (state)
      IDLE: begin
        cnt_next     = '0;
        bit_cnt_next = '0;
        if (prev_line && !line) begin
          state_next = START;
          per_next   = clamp_period(period);
        end
      end
      START: begin
        if (cnt == half_m1) begin
          cnt_next   = '0;
          state_next = line ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == per_m1) begin
          cnt_next     = '0;
          shift_next   = {line, shift_q[DATA_W-1:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'(DATA_W - 1)) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (cnt == per_m1) begin
          cnt_next   = '0;
          state_next = IDLE;
          commit     = line;
          frame_set  = ~line;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign clear_acc   = rx_clear & rx_ready;
  assign overrun_set = commit & full & ~clear_acc;

`ifdef UART_RX_FIFO_EN
  logic fifo_empty;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (commit),
    .pop   (clear_acc),
    .din   (shift_q),
    .dout  (rx_data),
    .empty (fifo_empty),
    .full  (full)
  );

  assign rx_ready = ~fifo_empty;
`else
  logic [DATA_W-1:0] hold_q;
  logic              hold_valid;

  // A clear on the commit cycle frees the register just in time for the new byte.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_q     <= '0;
      hold_valid <= 1'b0;
    end else if (commit && (!hold_valid || clear_acc)) begin
      hold_q     <= shift_q;
      hold_valid <= 1'b1;
    end else if (clear_acc) begin
      hold_valid <= 1'b0;
    end
  end

  assign rx_data  = hold_q;
  assign rx_ready = hold_valid;
  assign full     = hold_valid;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_set | (frame_err & ~clear_acc);
      overrun   <= overrun_set | (overrun & ~clear_acc);
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized self-checking bench for uart_receiver against a byte-queue model
// of the receive storage and flags.
module tb_uart_receiver;

`ifdef UART_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] period = 16'd16;
  logic        rxd = 1'b1;
  logic        rx_clear = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        frame_err;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model_q[$];
  bit         m_ferr = 1'b0;
  bit         m_ovr  = 1'b0;

  uart_receiver #(
    .SYNC_STAGES (2),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .period    (period),
    .rxd       (rxd),
    .rx_clear  (rx_clear),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_ready"}, 16'(rx_ready), 16'(model_q.size() > 0));
    if (model_q.size() > 0) checkOutput({tag, "_data"}, 16'(rx_data), 16'(model_q[0]));
    checkOutput({tag, "_frame_err"}, 16'(frame_err), 16'(m_ferr));
    checkOutput({tag, "_overrun"}, 16'(overrun), 16'(m_ovr));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Storage/flag rules: an accepted clear pops and clears flags, then a good
  // byte is stored if room remains, otherwise it is dropped as overrun.
  task automatic modelCommit(input logic [7:0] b, input bit good, input bit clr);
    if (clr && model_q.size() > 0) begin
      void'(model_q.pop_front());
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
    end
    if (!good) m_ferr = 1'b1;
    else if (model_q.size() < CAP) model_q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic clearPulse();
    rx_clear = 1'b1;
    @(posedge clk);
    #1;
    rx_clear = 1'b0;
    if (model_q.size() > 0) begin
      void'(model_q.pop_front());
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
    end
  endtask

  task automatic readByte(input string tag);
    if (model_q.size() > 0) checkOutput({tag, "_read"}, 16'(rx_data), 16'(model_q[0]));
    clearPulse();
  endtask

  // Drives one 8N1 frame, p clocks per bit, then 4 idle clocks. The stop
  // sample lands 2 sync stages + 1 edge-detect clock + p/2 + 9p clocks after
  // the line falls, which is where clr_at and the timing checks aim.
  task automatic applyStimulus(input logic [7:0] data, input int p, input bit stop_bit,
                               input int clr_at, input bit chk_timing,
                               input bit chg, input logic [15:0] chg_to);
    for (int c = 0; c < 10 * p + 4; c++) begin
      if (chk_timing && c == 2 + p / 2 + 9 * p)
        checkOutput("ready_before_commit", 16'(rx_ready), 16'(model_q.size() > 0));
      if (chk_timing && c == 3 + p / 2 + 9 * p)
        checkOutput("ready_after_commit", 16'(rx_ready), 16'd1);
      if (c < p) rxd = 1'b0;
      else if (c < 9 * p) rxd = data[c / p - 1];
      else if (c < 10 * p) rxd = stop_bit;
      else rxd = 1'b1;
      rx_clear = (c == clr_at);
      if (chg && c == p) period = chg_to;
      @(posedge clk);
      #1;
    end
    rx_clear = 1'b0;
  endtask

  task automatic sendGood(input logic [7:0] b, input int p);
    applyStimulus(b, p, 1'b1, -1, 1'b0, 1'b0, 16'd0);
    modelCommit(b, 1'b1, 1'b0);
  endtask

  task automatic drain(input string tag);
    while (model_q.size() > 0) readByte(tag);
  endtask

  initial begin
    logic [7:0] b;
    int         p;
    int         r;

    idle(3);
    checkOutput("reset_data", 16'(rx_data), 16'h00);
    checkOutput("reset_ready", 16'(rx_ready), 16'd0);
    checkOutput("reset_frame_err", 16'(frame_err), 16'd0);
    checkOutput("reset_overrun", 16'(overrun), 16'd0);
    rstn = 1'b1;
    idle(3);

    // Basic byte with exact ready timing.
    applyStimulus(8'hA5, 16, 1'b1, -1, 1'b1, 1'b0, 16'd0);
    modelCommit(8'hA5, 1'b1, 1'b0);
    checkState("a5");
    readByte("a5");
    checkState("a5_after_read");

    // Short low glitch is rejected without raising a flag.
    rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    idle(40);
    checkState("glitch");
    sendGood(8'hC3, 16);
    checkState("after_glitch");
    drain("after_glitch");

    // Framing error, sticky through an ignored clear, cleared by an accepted one.
    applyStimulus(8'h3C, 16, 1'b0, -1, 1'b0, 1'b0, 16'd0);
    modelCommit(8'h3C, 1'b0, 1'b0);
    checkState("ferr");
    clearPulse();
    checkState("ferr_empty_clear");
    sendGood(8'h66, 16);
    checkState("ferr_then_good");
    readByte("ferr_clear");
    checkState("ferr_cleared");

    // Overrun: one byte more than storage holds, stored bytes kept in order.
    for (int i = 0; i <= CAP; i++) sendGood(8'(8'h11 * (i + 1)), 16);
    checkState("overrun");
    checkOutput("overrun_head", 16'(rx_data), 16'h11);
    drain("overrun");
    checkState("overrun_drained");

    // Full storage with a clear exactly on the commit cycle.
    for (int i = 0; i < CAP; i++) sendGood(8'($urandom_range(0, 255)), 16);
    b = 8'($urandom_range(0, 255));
    applyStimulus(b, 16, 1'b1, 2 + 8 + 9 * 16, 1'b0, 1'b0, 16'd0);
    modelCommit(b, 1'b1, 1'b1);
    checkState("coincident");
    checkOutput("coincident_tail", 16'(model_q[model_q.size() - 1]), 16'(b));
    drain("coincident");

    // Reset in the middle of the data bits abandons the frame.
    for (int c = 0; c < 4 * 16; c++) begin
      b = 8'hF0;
      rxd = (c < 16) ? 1'b0 : b[c / 16 - 1];
      idle(1);
    end
    rstn = 1'b0;
    rxd  = 1'b1;
    idle(3);
    rstn = 1'b1;
    model_q.delete();
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    idle(2);
    checkState("mid_reset");
    checkOutput("mid_reset_data", 16'(rx_data), 16'h00);
    sendGood(8'h5A, 16);
    checkState("after_reset");
    drain("after_reset");
    idle(20);
    checkState("no_partial");

    // Period change mid-frame affects only the next frame.
    period = 16'd16;
    applyStimulus(8'h96, 16, 1'b1, -1, 1'b0, 1'b1, 16'd5);
    modelCommit(8'h96, 1'b1, 1'b0);
    checkState("period_change");
    drain("period_change");
    sendGood(8'h4B, 5);
    checkState("new_period");
    drain("new_period");

    // Divisors below 2 behave as 2.
    period = 16'd0;
    sendGood(8'hE7, 2);
    checkState("period0");
    drain("period0");
    period = 16'd1;
    sendGood(8'h18, 2);
    checkState("period1");
    drain("period1");

    // Random traffic.
    for (int i = 0; i < 30; i++) begin
      p = $urandom_range(2, 24);
      period = 16'(p);
      if (p == 2 && $urandom_range(0, 1) == 1) period = 16'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      b = 8'($urandom_range(0, 255));
      if (r < 7) begin
        sendGood(b, p);
      end else if (r == 7) begin
        applyStimulus(b, p, 1'b0, -1, 1'b0, 1'b0, 16'd0);
        modelCommit(b, 1'b0, 1'b0);
      end else begin
        readByte("rand");
      end
      checkState("rand");
      idle($urandom_range(0, 5));
    end
    drain("final");
    checkState("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
